// File: rtl/sram_fetch_buffer.sv
// ---------------------------------------------------------------------------
// sram_fetch_buffer
// Read-side client of a 1R1W instruction SRAM. Generates sequential word
// addresses, issues reads, captures dout1 one cycle after issue, queues the
// {addr, data} pairs in a small FIFO and presents them to the fetch stage over
// a valid/ready handshake. A redirect flushes queued and in-flight words and
// restarts fetch at a new address.
//
// Optional feature (macro FETCH_STATS_EN): adds saturating counters
// stat_reads (issued reads) and stat_drops (responses dropped by redirect).
//
// Ports:
//   clk            : clock, shared with SRAM clk1
//   rst            : asynchronous active-high reset
//   enable         : fetch permitted when high
//   redirect_valid : one-cycle pulse, restart fetch at redirect_addr
//   redirect_addr  : new fetch word address
//   instr_valid    : FIFO head valid
//   instr_data     : FIFO head word (last popped word when empty)
//   instr_addr     : FIFO head word address (last popped address when empty)
//   instr_ready    : core accepts head this cycle
//   csb1           : SRAM read chip select, active low
//   addr1          : SRAM read address
//   dout1          : SRAM read data
//   stat_reads     : (FETCH_STATS_EN) issued read count, saturating
//   stat_drops     : (FETCH_STATS_EN) dropped response count, saturating
// ---------------------------------------------------------------------------
module sram_fetch_buffer #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_ready,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]           stat_reads,
    output logic [15:0]           stat_drops
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;
    logic [ADDR_WIDTH-1:0] r_addr1_last;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_last_data;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    entry_t                r_mem [DEPTH];

    logic   w_issue;
    logic   w_push;
    logic   w_pop;
    logic   w_not_empty;
    entry_t w_head;

    // Credit check counts the in-flight read so a captured response always fits.
    assign w_not_empty = (r_count != '0);
    assign w_issue     = (r_state == S_RUN) && !redirect_valid &&
                         ((r_count + CNT_W'(r_inflight)) < CNT_W'(DEPTH));
    assign w_push      = r_inflight && !redirect_valid;
    assign w_pop       = w_not_empty && instr_ready && !redirect_valid;
    assign w_head      = r_mem[r_rd_ptr];

    // SRAM read port: address follows pc only while issuing, else holds.
    assign csb1  = !w_issue;
    assign addr1 = w_issue ? r_pc : r_addr1_last;

    // Head presentation; empty FIFO shows the most recently popped word.
    assign instr_valid = w_not_empty;
    assign instr_data  = w_not_empty ? w_head.data : r_last_data;
    assign instr_addr  = w_not_empty ? w_head.addr : r_last_addr;

    // FIFO storage, written on capture of the in-flight response.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_inflight_addr, dout1};
        end
    end

    // Fetch FSM, issue tracking and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_pc            <= ADDR_WIDTH'(RESET_ADDR);
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_addr1_last    <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_last_data     <= '0;
            r_last_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (enable)  r_state <= S_RUN;
                S_RUN:   if (!enable) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (redirect_valid) begin
                // Flush wins over everything; in-flight response is dropped.
                r_pc       <= redirect_addr;
                r_inflight <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_inflight      <= 1'b1;
                    r_inflight_addr <= r_pc;
                    r_addr1_last    <= r_pc;
                    r_pc            <= r_pc + ADDR_WIDTH'(1);
                end else begin
                    r_inflight <= 1'b0;
                end

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end

                if (w_pop) begin
                    r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                    r_last_data <= w_head.data;
                    r_last_addr <= w_head.addr;
                end

                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] r_stat_reads;
    logic [15:0] r_stat_drops;

    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads <= '0;
            r_stat_drops <= '0;
        end else begin
            if (w_issue && (r_stat_reads != 16'hFFFF)) begin
                r_stat_reads <= r_stat_reads + 16'd1;
            end
            if (redirect_valid && r_inflight && (r_stat_drops != 16'hFFFF)) begin
                r_stat_drops <= r_stat_drops + 16'd1;
            end
        end
    end

    assign stat_reads = r_stat_reads;
    assign stat_drops = r_stat_drops;
`else
    // Statistics counters not built.
`endif

endmodule

// File: tb/tb_sram_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_sram_fetch_buffer
// Bench for sram_fetch_buffer: SRAM read-port model, a transaction-level
// reference (queue of words issued since the last flush) checked every cycle,
// and directed/random scenario tasks with their own inline checks.
// ---------------------------------------------------------------------------
module tb_sram_fetch_buffer;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RESET_ADDR = 11'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_addr;
    logic          instr_ready = 1'b0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1 = '0;
`ifdef FETCH_STATS_EN
    logic [15:0]   stat_reads;
    logic [15:0]   stat_drops;
`endif

    int checks = 0;
    int errors = 0;

    sram_fetch_buffer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_ADDR(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr),
        .instr_ready   (instr_ready),
        .csb1          (csb1),
        .addr1         (addr1),
        .dout1         (dout1)
`ifdef FETCH_STATS_EN
        ,
        .stat_reads    (stat_reads),
        .stat_drops    (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    // SRAM read port: sample at the edge, data valid during the next cycle.
    logic [DW-1:0] sram_mem [2048];
    always @(posedge clk) begin
        if (!csb1) dout1 <= sram_mem[addr1];
    end

    // Reference model: every word issued since the last flush, oldest first,
    // with the cycle in which it becomes visible to the core.
    typedef struct {
        logic [AW-1:0] addr;
        int            rdy;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    bit            m_run = 1'b0;
    bit            m_inflight = 1'b0;
    logic [AW-1:0] m_pc = RESET_ADDR;
    logic [AW-1:0] m_last_addr1 = '0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_last_data = '0;
    int            m_reads = 0;
    int            m_drops = 0;
    int            m_pops = 0;
    bit            exp_issue;
    bit            exp_valid;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_run        = 1'b0;
            m_inflight   = 1'b0;
            m_pc         = RESET_ADDR;
            m_last_addr1 = '0;
            m_last_addr  = '0;
            m_last_data  = '0;
            m_reads      = 0;
            m_drops      = 0;
        end else begin
            exp_issue = m_run && !redirect_valid && (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);

            checks++;
            if (csb1 !== !exp_issue) begin
                errors++;
                $display("FAIL mon_csb1 cyc=%0d got=%b exp=%b", cyc, csb1, !exp_issue);
            end
            checks++;
            if (addr1 !== (exp_issue ? m_pc : m_last_addr1)) begin
                errors++;
                $display("FAIL mon_addr1 cyc=%0d got=%0d exp=%0d", cyc, addr1,
                         exp_issue ? m_pc : m_last_addr1);
            end
            checks++;
            if (instr_valid !== exp_valid) begin
                errors++;
                $display("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (instr_addr !== q[0].addr || instr_data !== sram_mem[q[0].addr]) begin
                    errors++;
                    $display("FAIL mon_head cyc=%0d got=%0d/%h exp=%0d/%h", cyc, instr_addr,
                             instr_data, q[0].addr, sram_mem[q[0].addr]);
                end
            end else begin
                checks++;
                if (instr_addr !== m_last_addr || instr_data !== m_last_data) begin
                    errors++;
                    $display("FAIL mon_hold cyc=%0d got=%0d/%h exp=%0d/%h", cyc, instr_addr,
                             instr_data, m_last_addr, m_last_data);
                end
            end
`ifdef FETCH_STATS_EN
            checks++;
            if (stat_reads !== 16'((m_reads > 65535) ? 65535 : m_reads) ||
                stat_drops !== 16'((m_drops > 65535) ? 65535 : m_drops)) begin
                errors++;
                $display("FAIL mon_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stat_reads,
                         stat_drops, m_reads, m_drops);
            end
`endif
            // Advance the model across the coming clock edge.
            if (redirect_valid) begin
                if (m_inflight) m_drops++;
                q.delete();
                m_pc       = redirect_addr;
                m_inflight = 1'b0;
            end else begin
                if (exp_valid && instr_ready) begin
                    m_last_addr = q[0].addr;
                    m_last_data = sram_mem[q[0].addr];
                    void'(q.pop_front());
                    m_pops++;
                end
                if (exp_issue) begin
                    q.push_back('{addr: m_pc, rdy: cyc + 2});
                    m_last_addr1 = m_pc;
                    m_pc         = m_pc + 11'd1;
                    m_reads++;
                end
                m_inflight = exp_issue;
            end
            m_run = enable;
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive_slot();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (csb1 !== 1'b1 || addr1 !== '0) begin
            errors++;
            $display("FAIL reset_port got csb1=%b addr1=%0d exp csb1=1 addr1=0", csb1, addr1);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== '0 || instr_addr !== '0) begin
            errors++;
            $display("FAIL reset_head got v=%b d=%h a=%0d exp v=0 d=0 a=0",
                     instr_valid, instr_data, instr_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        bit found;
        int n;
        enable = 1'b1;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!csb1) found = 1'b1;
        end
        checks++;
        if (!found || addr1 !== RESET_ADDR) begin
            errors++;
            $display("FAIL stream_first_issue got found=%b addr1=%0d exp found=1 addr1=%0d",
                     found, addr1, RESET_ADDR);
        end
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            n++;
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || n != 2) begin
            errors++;
            $display("FAIL stream_latency got %0d cycles exp 2", n);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_addr !== 11'(k) || instr_data !== sram_mem[k]) begin
                errors++;
                $display("FAIL stream_word%0d got v=%b a=%0d d=%h exp v=1 a=%0d d=%h", k,
                         instr_valid, instr_addr, instr_data, k, sram_mem[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int  n;
        bit  found;
        enable = 1'b1;
        instr_ready = 1'b0;
        pulse_reset();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!csb1) n++;
        end
        checks++;
        if (n != DEPTH || csb1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_issue_count got %0d csb1=%b exp %0d csb1=1", n, csb1, DEPTH);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 11'd0) begin
            errors++;
            $display("FAIL bp_head got v=%b a=%0d exp v=1 a=0", instr_valid, instr_addr);
        end
        drive_slot();
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!csb1) found = 1'b1;
        end
        checks++;
        if (!found || addr1 !== 11'd4) begin
            errors++;
            $display("FAIL bp_resume got found=%b addr1=%0d exp found=1 addr1=4", found, addr1);
        end
    endtask

    task automatic test_redirect();
        bit found;
        enable = 1'b1;
        instr_ready = 1'b1;
        pulse_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!csb1 && addr1 == 11'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_wait_addr5 got timeout exp issue of addr 5");
        end
        drive_slot();
        redirect_valid = 1'b1;
        redirect_addr = 11'h100;
        @(negedge clk);
        checks++;
        if (csb1 !== 1'b1) begin
            errors++;
            $display("FAIL redir_no_issue got csb1=%b exp 1", csb1);
        end
        drive_slot();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || csb1 !== 1'b0 || addr1 !== 11'h100) begin
            errors++;
            $display("FAIL redir_first_issue got v=%b csb1=%b addr1=%h exp v=0 csb1=0 addr1=100",
                     instr_valid, csb1, addr1);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_dropped got v=%b a=%h exp v=0", instr_valid, instr_addr);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 11'h100) begin
            errors++;
            $display("FAIL redir_first_word got v=%b a=%h exp v=1 a=100", instr_valid, instr_addr);
        end
    endtask

    task automatic test_wrap();
        enable = 1'b1;
        instr_ready = 1'b1;
        drive_slot();
        redirect_valid = 1'b1;
        redirect_addr = 11'd2046;
        drive_slot();
        redirect_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (csb1 !== 1'b0 || addr1 !== 11'(2046 + k)) begin
                    errors++;
                    $display("FAIL wrap_addr1_%0d got csb1=%b addr1=%0d exp csb1=0 addr1=%0d",
                             k, csb1, addr1, 11'(2046 + k));
                end
            end
            if (k >= 2) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_addr !== 11'(2044 + k)) begin
                    errors++;
                    $display("FAIL wrap_instr_%0d got v=%b a=%0d exp v=1 a=%0d",
                             k, instr_valid, instr_addr, 11'(2044 + k));
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bit found;
        enable = 1'b1;
        drive_slot();
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 11'h040;
        drive_slot();
        redirect_valid = 1'b0;
        // Three issues later: two words queued and a third in flight.
        repeat (3) drive_slot();
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== 11'h040) begin
            errors++;
            $display("FAIL midrst_pre got v=%b a=%h exp v=1 a=40", instr_valid, instr_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || csb1 !== 1'b1 || instr_addr !== '0) begin
            errors++;
            $display("FAIL midrst_async got v=%b csb1=%b a=%0d exp v=0 csb1=1 a=0",
                     instr_valid, csb1, instr_addr);
        end
        drive_slot();
        rst = 1'b0;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!csb1) found = 1'b1;
        end
        checks++;
        if (!found || addr1 !== RESET_ADDR) begin
            errors++;
            $display("FAIL midrst_restart got found=%b addr1=%0d exp found=1 addr1=%0d",
                     found, addr1, RESET_ADDR);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        checks++;
        if (!found || instr_addr !== RESET_ADDR) begin
            errors++;
            $display("FAIL midrst_first_word got found=%b a=%0d exp found=1 a=%0d",
                     found, instr_addr, RESET_ADDR);
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        int n;
        enable = 1'b1;
        instr_ready = 1'b1;
        pulse_reset();
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            @(negedge clk);
            if (!csb1) n++;
        end
        drive_slot();
        redirect_valid = 1'b1;
        redirect_addr = '0;
        enable = 1'b0;
        drive_slot();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (n != 10 || stat_reads !== 16'd10 || stat_drops !== 16'd1) begin
            errors++;
            $display("FAIL stats got issues=%0d reads=%0d drops=%0d exp 10/10/1",
                     n, stat_reads, stat_drops);
        end
        enable = 1'b1;
    endtask
`endif

    task automatic test_random();
        int pops_before;
        pops_before = m_pops;
        for (int i = 0; i < 3000; i++) begin
            drive_slot();
            enable         = ($urandom_range(0, 7) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 11'(2044 + $urandom_range(0, 3))
                                                         : 11'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                drive_slot();
                rst = 1'b0;
            end
        end
        drive_slot();
        redirect_valid = 1'b0;
        enable = 1'b0;
        repeat (4) drive_slot();
        checks++;
        if (m_pops - pops_before < 100) begin
            errors++;
            $display("FAIL random_progress got %0d words delivered exp >= 100",
                     m_pops - pops_before);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) sram_mem[i] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midop();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
